// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus blocks: arbiter state encoding and
// bus field widths.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int ADDR_BITS = 16;
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/counter.sv
// Up-counter with asynchronous clear, used for the arbiter grant timeout.
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             rst,
    input  logic             CLK,
    input  logic             incr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // next count: step when enabled, otherwise hold
    always_comb begin
        if (incr) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bus_arbiter.sv
// Serial bus arbiter: one-hot grant held for a whole transaction, round-robin
// or fixed priority, with revocation of grants that are never used.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS   = 2,
    parameter int TIMEOUT     = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [N_MASTERS-1:0]         M_REQ,
    output logic [N_MASTERS-1:0]         M_GRANT,
    output logic [$clog2(N_MASTERS)-1:0] B_MSEL,
    output logic                         B_GRANTED,
    input  logic                         B_UTIL,
    input  logic                         B_SBSY,
    output logic                         ARB_TIMEOUT
);

    localparam int SEL_W = $clog2(N_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]     msel_q, msel_d;
    logic                 granted_q, granted_d;
    logic                 timeout_q, timeout_d;
    logic [SEL_W-1:0]     last_owner_q, last_owner_d;
    logic                 cnt_clr_q;
    logic                 cnt_rst_s;
    logic [CNT_W-1:0]     tmo_cnt_s;
    logic [SEL_W-1:0]     win_s;

    // Search wraps explicitly so non-power-of-two master counts stay in range.
    function automatic logic [SEL_W-1:0] pick_winner(
        input logic [N_MASTERS-1:0] req,
        input logic [SEL_W-1:0]     last
    );
        logic [SEL_W-1:0] w;
        logic             found;
        int unsigned      idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (ROUND_ROBIN != 0) begin
                idx = 32'(last) + 32'(i) + 32'd1;
                if (idx >= 32'(N_MASTERS)) begin
                    idx = idx - 32'(N_MASTERS);
                end else begin
                    idx = idx;
                end
            end else begin
                idx = 32'(i);
            end
            if (!found && req[idx[SEL_W-1:0]]) begin
                found = 1'b1;
                w     = idx[SEL_W-1:0];
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    assign win_s = pick_winner(M_REQ, last_owner_q);

    // The clear is registered so the counter's async clear never sees decode glitches.
    assign cnt_rst_s = RST | cnt_clr_q;

    counter #(.WIDTH(CNT_W)) u_tmo_cnt (
        .rst   (cnt_rst_s),
        .CLK   (CLK),
        .incr  (state_q == GRANT),
        .count (tmo_cnt_s)
    );

    // next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        msel_d       = msel_q;
        granted_d    = granted_q;
        timeout_d    = 1'b0;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (|M_REQ) begin
                    state_d   = GRANT;
                    grant_d   = N_MASTERS'(1) << win_s;
                    msel_d    = win_s;
                    granted_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (B_UTIL) begin
                    state_d = BUSY;
                end else if (!M_REQ[msel_q]) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    granted_d = 1'b0;
                end else if (tmo_cnt_s == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    granted_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = GRANT;
                end
            end
            BUSY: begin
                if (!B_UTIL && !B_SBSY) begin
                    state_d   = RELEASE;
                    grant_d   = '0;
                    granted_d = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            RELEASE: begin
                state_d      = IDLE;
                last_owner_d = msel_q;
            end
            default: begin
                state_d   = IDLE;
                grant_d   = '0;
                granted_d = 1'b0;
            end
        endcase
    end

    // state, outputs and arbitration history
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            msel_q       <= '0;
            granted_q    <= 1'b0;
            timeout_q    <= 1'b0;
            last_owner_q <= SEL_W'(N_MASTERS - 1);
            cnt_clr_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            msel_q       <= msel_d;
            granted_q    <= granted_d;
            timeout_q    <= timeout_d;
            last_owner_q <= last_owner_d;
            cnt_clr_q    <= (state_d != GRANT);
        end
    end

    assign M_GRANT     = grant_q;
    assign B_MSEL      = msel_q;
    assign B_GRANTED   = granted_q;
    assign ARB_TIMEOUT = timeout_q;

endmodule
